// File: rtl/forward_sequencer_pkg.sv
// Shared definitions for the forward sequencer: opcodes, FSM states and the
// default instruction-word layout (opcode, x_base, y_base, w_base, len_in, len_out).
// Latency/backpressure: definitions only, no logic.
package forward_sequencer_pkg;

  localparam int DEF_XY_ADDR_W = 10;
  localparam int DEF_W_ADDR_W  = 12;
  localparam int DEF_LEN_W     = 8;

  typedef enum logic [3:0] {
    NOP         = 4'h0,
    FORWARD_ACT = 4'h1,
    FORWARD_LIN = 4'h2,
    HALT        = 4'hF
  } forward_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MATMUL,
    S_DRAIN,
    S_ACCMOV,
    S_FLUSH,
    S_HALTED
  } seq_state_t;

  // Field layout of the instruction word at the default widths, MSB first.
  typedef struct packed {
    logic [3:0]               opcode;
    logic [DEF_XY_ADDR_W-1:0] x_base;
    logic [DEF_XY_ADDR_W-1:0] y_base;
    logic [DEF_W_ADDR_W-1:0]  w_base;
    logic [DEF_LEN_W-1:0]     len_in;
    logic [DEF_LEN_W-1:0]     len_out;
  } forward_inst_t;

endpackage

// File: rtl/forward_sequencer_delay_line.sv
// Fixed-depth shift register with asynchronous clear; a plain wire at DEPTH = 0.
// Latency: DEPTH cycles.
// Backpressure: none, shifts every cycle.
module forward_sequencer_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clk ^ reset;
      assign o_dat    = i_dat;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift one stage per cycle; reset wipes every stage so nothing stale emerges.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= i_dat;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_dat = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/forward_sequencer.sv
// Per-layer forward controller: MATMUL -> DRAIN -> ACCMOV -> FLUSH per accepted instruction.
// Latency: len_in+1 + MAC_LATENCY + L+1 + ACT_LATENCY cycles, done one cycle later.
// Backpressure: inst_ready only in IDLE. FORWARD_SEQ_PERF_EN adds perf_busy_cycles.
module forward_sequencer
  import forward_sequencer_pkg::*;
#(
  parameter int NU_COUNT    = 8,
  parameter int XY_ADDR_W   = 10,
  parameter int W_ADDR_W    = 12,
  parameter int LEN_W       = 8,
  parameter int MAC_LATENCY = 2,
  parameter int ACT_LATENCY = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        inst_valid,
  output logic                                        inst_ready,
  input  logic [4+2*XY_ADDR_W+W_ADDR_W+2*LEN_W-1:0]   inst_data,
  output logic [NU_COUNT-1:0]                         mac_reg_enable,
  output logic                                        mac_acc_loopback,
  output logic                                        serializer_update,
  output logic                                        act_bypass,
  output logic [XY_ADDR_W-1:0]                        xy_read_addr,
  output logic [W_ADDR_W-1:0]                         w_read_addr,
  output logic [XY_ADDR_W-1:0]                        xy_write_addr,
  output logic                                        xy_write_enable,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        halted,
  output logic                                        err
`ifdef FORWARD_SEQ_PERF_EN
  ,
  output logic [31:0]                                 perf_busy_cycles
`endif
);

  localparam int INST_W = 4 + 2*XY_ADDR_W + W_ADDR_W + 2*LEN_W;

  logic [3:0]           w_op;
  logic [XY_ADDR_W-1:0] w_x_base, w_y_base;
  logic [W_ADDR_W-1:0]  w_w_base;
  logic [LEN_W-1:0]     w_len_in, w_len_out;
  logic                 w_accept, w_is_fwd, w_illegal, w_len_ovf;
  logic                 w_busy, w_beat_vld, w_done_set;
  logic [XY_ADDR_W-1:0] w_beat_addr;
  logic [XY_ADDR_W:0]   w_pipe_out;
  seq_state_t           r_state, w_next;

  logic [LEN_W-1:0]     r_k, r_len_in, r_last;
  logic [15:0]          r_wait;
  logic [XY_ADDR_W-1:0] r_x_base, r_y_base;
  logic [W_ADDR_W-1:0]  r_w_base;
  logic                 r_bypass, r_err, r_done;

  assign w_op      = inst_data[INST_W-1 -: 4];
  assign w_x_base  = inst_data[INST_W-5 -: XY_ADDR_W];
  assign w_y_base  = inst_data[INST_W-5-XY_ADDR_W -: XY_ADDR_W];
  assign w_w_base  = inst_data[2*LEN_W+W_ADDR_W-1 -: W_ADDR_W];
  assign w_len_in  = inst_data[2*LEN_W-1 -: LEN_W];
  assign w_len_out = inst_data[LEN_W-1:0];

  assign inst_ready = (r_state == S_IDLE);
  assign w_accept   = inst_valid && inst_ready;
  assign w_is_fwd   = (w_op == FORWARD_ACT) || (w_op == FORWARD_LIN);
  assign w_illegal  = !(w_is_fwd || (w_op == NOP) || (w_op == HALT));
  assign w_len_ovf  = (32'(w_len_out) >= 32'(NU_COUNT));
  assign w_busy     = (r_state == S_MATMUL) || (r_state == S_DRAIN) ||
                      (r_state == S_ACCMOV) || (r_state == S_FLUSH);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and phase outputs; DRAIN/FLUSH lengths come from the latency parameters.
  always_comb begin
    w_next            = r_state;
    mac_reg_enable    = '0;
    mac_acc_loopback  = 1'b0;
    serializer_update = 1'b0;
    xy_read_addr      = '0;
    w_read_addr       = '0;
    w_beat_vld        = 1'b0;
    w_beat_addr       = '0;
    w_done_set        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_fwd)          w_next = S_MATMUL;
          else if (w_op == HALT) w_next = S_HALTED;
        end
      end
      S_MATMUL: begin
        mac_reg_enable   = '1;
        mac_acc_loopback = (r_k != '0);
        xy_read_addr     = r_x_base + XY_ADDR_W'(r_k);
        w_read_addr      = r_w_base + W_ADDR_W'(r_k);
        if (r_k == r_len_in) w_next = (MAC_LATENCY == 0) ? S_ACCMOV : S_DRAIN;
      end
      S_DRAIN: begin
        if (32'(r_wait) == 32'(MAC_LATENCY - 1)) w_next = S_ACCMOV;
      end
      S_ACCMOV: begin
        serializer_update = (r_k == '0);
        w_beat_vld        = 1'b1;
        w_beat_addr       = r_y_base + XY_ADDR_W'(r_k);
        if (r_k == r_last) begin
          if (ACT_LATENCY == 0) begin
            w_next     = S_IDLE;
            w_done_set = 1'b1;
          end else begin
            w_next = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (32'(r_wait) == 32'(ACT_LATENCY - 1)) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end
      S_HALTED: w_next = S_HALTED;
      default:  w_next = S_IDLE;
    endcase
  end

  // Phase counters restart on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k    <= '0;
      r_wait <= '0;
    end else if (w_next != r_state) begin
      r_k    <= '0;
      r_wait <= '0;
    end else begin
      if (r_state == S_MATMUL || r_state == S_ACCMOV) r_k    <= r_k + LEN_W'(1);
      if (r_state == S_DRAIN  || r_state == S_FLUSH)  r_wait <= r_wait + 16'd1;
    end
  end

  // Latch instruction fields on acceptance; ACCMOV length is clamped to the lane count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x_base <= '0;
      r_y_base <= '0;
      r_w_base <= '0;
      r_len_in <= '0;
      r_last   <= '0;
      r_bypass <= 1'b0;
    end else if (w_accept) begin
      r_x_base <= w_x_base;
      r_y_base <= w_y_base;
      r_w_base <= w_w_base;
      r_len_in <= w_len_in;
      r_last   <= w_len_ovf ? LEN_W'(NU_COUNT - 1) : w_len_out;
      r_bypass <= (w_op == FORWARD_LIN);
    end
  end

  // Sticky error for unknown opcodes and over-long output runs; done pulses on return to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_accept && (w_illegal || (w_is_fwd && w_len_ovf))) r_err <= 1'b1;
      r_done <= w_done_set;
    end
  end

  forward_sequencer_delay_line #(
    .DEPTH (ACT_LATENCY),
    .WIDTH (XY_ADDR_W + 1)
  ) u_write_delay (
    .clk   (clk),
    .reset (reset),
    .i_dat ({w_beat_vld, w_beat_addr}),
    .o_dat (w_pipe_out)
  );

  assign xy_write_enable = w_pipe_out[XY_ADDR_W];
  assign xy_write_addr   = w_pipe_out[XY_ADDR_W-1:0];
  assign act_bypass      = w_busy && r_bypass;
  assign busy            = w_busy;
  assign done            = r_done;
  assign halted          = (r_state == S_HALTED);
  assign err             = r_err;

`ifdef FORWARD_SEQ_PERF_EN
  logic [31:0] r_perf;

  // Saturating count of busy cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_perf <= '0;
    else if (w_busy && r_perf != 32'hFFFF_FFFF)  r_perf <= r_perf + 32'd1;
  end

  assign perf_busy_cycles = r_perf;
`endif

endmodule
